kuz_block_arbiter: RTL and testbench

- Sequences the Kuznechik cipher core and shares it between two block requesters (UART front-end and a second host channel).
- After reset it runs key expansion once, then round-robin grants 128-bit blocks into the core with the put pulse and key select.
- A tag FIFO records which requester owns each in-flight block; each cipher_ready result is routed back to that requester.
- Sits between the requester front-ends and the cipher core instance.

---
 rtl/kuz_block_arbiter.sv | 81 ++++++++
 tb/tb_kuz_block_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/kuz_block_arbiter.sv
// kuz_block_arbiter: sequences key expansion, then round-robin shares the Kuznechik core between two requesters
module kuz_block_arbiter #(
  parameter int MAX_OUT = 4,
  parameter int MIN_GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic         req0_key_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  input  logic         req1_key_sel,
  output logic         core_start_key,
  output logic         core_put,
  output logic         core_key_sel,
  output logic [127:0] core_block,
  input  logic         core_keys_ready,
  input  logic         core_cipher_ready,
  input  logic [127:0] core_result,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [127:0] rsp_block,
  output logic [4:0]   outstanding,
  output logic         err_unexpected
);
  typedef enum logic [1:0] {INIT, WAIT_KEYS, RUN} state_t;
  localparam int GW = MIN_GAP > 1 ? $clog2(MIN_GAP) : 1;
  state_t state;
  logic [GW-1:0] gap_cnt;
  logic [15:0] tags, tags_n;
  logic [3:0] wr_idx;
  logic rr, grant, can_issue, hs, pop;
  // tags is a shift queue: bit 0 is the owner of the oldest in-flight block
  always_comb begin
    can_issue = state == RUN && gap_cnt == '0 && outstanding < 5'(MAX_OUT);
    grant = req0_valid && req1_valid ? rr : req1_valid;
    req0_ready = can_issue & ~grant;
    req1_ready = can_issue & grant;
    hs = can_issue & (grant ? req1_valid : req0_valid);
    pop = core_cipher_ready && outstanding != '0;
    wr_idx = 4'(outstanding - 5'(pop));
    tags_n = pop ? tags >> 1 : tags;
    if (hs) tags_n[wr_idx] = grant;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      core_start_key <= 1'b0;
      core_put <= 1'b0;
      core_key_sel <= 1'b0;
      core_block <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_block <= '0;
      outstanding <= '0;
      err_unexpected <= 1'b0;
      gap_cnt <= '0;
      tags <= '0;
      rr <= 1'b0;
    end else begin
      state <= state == INIT ? WAIT_KEYS : state == WAIT_KEYS && core_keys_ready ? RUN : state;
      core_start_key <= state == INIT;
      core_put <= hs;
      if (hs) begin
        core_block <= grant ? req1_block : req0_block;
        core_key_sel <= grant ? req1_key_sel : req0_key_sel;
        rr <= ~grant;
      end
      gap_cnt <= hs ? GW'(MIN_GAP - 1) : gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt;
      tags <= tags_n;
      outstanding <= outstanding + 5'(hs) - 5'(pop);
      rsp0_valid <= pop & ~tags[0];
      rsp1_valid <= pop & tags[0];
      if (pop) rsp_block <= core_result;
      err_unexpected <= err_unexpected | (core_cipher_ready && outstanding == '0);
    end
  end
endmodule

// File: tb/tb_kuz_block_arbiter.sv
// tb_kuz_block_arbiter: directed vectors plus a randomized run against a queue-based model
module tb_kuz_block_arbiter;
  localparam int MAX_A = 4;
  localparam int GAP_A = 1;
  localparam logic [127:0] B0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B1 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] RA = {16{8'haa}};
  logic clk = 1'b0, rst;
  logic v0, v1, k0, k1, keys, cr;
  logic [127:0] b0, b1, res;
  logic r0, r1, start_key, put, ks, s0, s1, err;
  logic [127:0] blk, rblk;
  logic [4:0] out;
  logic b_r0, b_r1, b_sk, b_put, b_ks, b_s0, b_s1, b_err;
  logic [127:0] b_blk, b_rblk;
  logic [4:0] b_out;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  kuz_block_arbiter #(.MAX_OUT(MAX_A), .MIN_GAP(GAP_A)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_block(b0), .req0_key_sel(k0),
    .req1_valid(v1), .req1_ready(r1), .req1_block(b1), .req1_key_sel(k1),
    .core_start_key(start_key), .core_put(put), .core_key_sel(ks), .core_block(blk),
    .core_keys_ready(keys), .core_cipher_ready(cr), .core_result(res),
    .rsp0_valid(s0), .rsp1_valid(s1), .rsp_block(rblk), .outstanding(out), .err_unexpected(err)
  );

  kuz_block_arbiter #(.MAX_OUT(4), .MIN_GAP(3)) dut_gap (
    .clk(clk), .rst(rst),
    .req0_valid(1'b0), .req0_ready(b_r0), .req0_block(B0), .req0_key_sel(1'b0),
    .req1_valid(1'b1), .req1_ready(b_r1), .req1_block(B1), .req1_key_sel(1'b1),
    .core_start_key(b_sk), .core_put(b_put), .core_key_sel(b_ks), .core_block(b_blk),
    .core_keys_ready(keys), .core_cipher_ready(1'b0), .core_result(RA),
    .rsp0_valid(b_s0), .rsp1_valid(b_s1), .rsp_block(b_rblk), .outstanding(b_out), .err_unexpected(b_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v0, v1, cr, r0, r1;
    int out;
    bit put, s0, s1;
  } vec_t;
  vec_t tbl[12];

  initial begin : gap_check
    int puts[$];
    for (int i = 0; i < 400 && keys !== 1'b1; i++) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b_put) puts.push_back(i);
    end
    chk("gap3 put count", puts.size(), 4);
    for (int k = 1; k < puts.size(); k++) chk("gap3 spacing", puts[k] - puts[k-1], 3);
    chk("gap3 stalled ready", b_r1, 0);
    chk("gap3 outstanding", b_out, 4);
  end

  initial begin : main
    int q[$];
    int last_hs, t;
    bit prio, can, win, hs, ok;
    bit e_put, e_ks, e_s0, e_s1;
    logic [127:0] e_blk, e_rblk;
    int drain_tags[4] = '{0, 1, 0, 1};
    tbl[0]  = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 1, 2, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 1, 0, 3, 1, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 4, 1, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 4, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 1, 3, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 0, 0, 4, 1, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 4, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 0, 3, 0, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 1, 3, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 4, 1, 0, 0};
    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b0; k0 = 1'b1; k1 = 1'b0; keys = 1'b0; cr = 1'b0;
    b0 = B0; b1 = B1; res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset start_key", start_key, 0);
    chk("reset put", put, 0);
    chk("reset block", blk, 0);
    chk("reset outstanding", out, 0);
    chk("reset ready0", r0, 0);
    chk("reset err", err, 0);
    rst = 1'b0;
    tick();
    chk("start_key pulse", start_key, 1);
    tick();
    chk("start_key drop", start_key, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no grant before keys", r0, 0);
      chk("no put before keys", put, 0);
    end
    keys = 1'b1;
    ok = 0;
    for (int i = 0; i < 2 && !ok; i++) begin
      tick();
      ok = r0;
    end
    chk("ready after keys", ok, 1);
    tick();
    v0 = 1'b0;
    chk("single put", put, 1);
    chk("single block", blk, B0);
    chk("single key_sel", ks, 1);
    chk("single outstanding", out, 1);
    tick();
    chk("put one cycle", put, 0);
    chk("block held", blk, B0);
    cr = 1'b1; res = RA;
    tick();
    cr = 1'b0;
    chk("single rsp0", s0, 1);
    chk("single rsp1", s1, 0);
    chk("single rsp_block", rblk, RA);
    chk("single outstanding back", out, 0);
    tick();
    chk("rsp0 one cycle", s0, 0);
    chk("rsp_block held", rblk, RA);
    for (int i = 0; i < 12; i++) begin
      tick();
      v0 = tbl[i].v0; v1 = tbl[i].v1; cr = tbl[i].cr;
      #1;
      chk($sformatf("tbl%0d ready0", i), r0, tbl[i].r0);
      chk($sformatf("tbl%0d ready1", i), r1, tbl[i].r1);
      chk($sformatf("tbl%0d outstanding", i), out, tbl[i].out);
      chk($sformatf("tbl%0d put", i), put, tbl[i].put);
      chk($sformatf("tbl%0d rsp0", i), s0, tbl[i].s0);
      chk($sformatf("tbl%0d rsp1", i), s1, tbl[i].s1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i > 0) begin
        chk("drain rsp0", s0, drain_tags[i-1] == 0);
        chk("drain rsp1", s1, drain_tags[i-1] == 1);
      end
      if (i == 4) chk("drain outstanding", out, 0);
      cr = i < 4;
      res = {4{32'hc0de0000 + 32'(i)}};
    end
    prio = 1'b0; last_hs = -100;
    e_put = 0; e_s0 = 0; e_s1 = 0; e_blk = B1; e_ks = 1'b0; e_rblk = {4{32'hc0de0003}};
    for (int n = 0; n < 400; n++) begin
      tick();
      chk("rnd put", put, e_put);
      chk("rnd block", blk, e_blk);
      chk("rnd key_sel", ks, e_ks);
      chk("rnd rsp0", s0, e_s0);
      chk("rnd rsp1", s1, e_s1);
      chk("rnd rsp_block", rblk, e_rblk);
      chk("rnd outstanding", out, q.size());
      v0 = n < 370 && $urandom_range(3) != 0;
      v1 = n < 370 && $urandom_range(3) != 0;
      b0 = {$urandom, $urandom, $urandom, $urandom};
      b1 = {$urandom, $urandom, $urandom, $urandom};
      k0 = $urandom_range(1); k1 = $urandom_range(1);
      cr = q.size() > 0 && (n >= 370 || $urandom_range(2) == 0);
      res = {$urandom, $urandom, $urandom, $urandom};
      #1;
      can = n - last_hs >= GAP_A && q.size() < MAX_A;
      win = v0 && v1 ? prio : v1;
      chk("rnd ready0", r0, can && !win);
      chk("rnd ready1", r1, can && win);
      hs = can && (v0 || v1);
      e_s0 = 0; e_s1 = 0;
      if (cr) begin
        t = q.pop_front();
        e_s0 = t == 0; e_s1 = t == 1; e_rblk = res;
      end
      e_put = hs;
      if (hs) begin
        e_blk = win ? b1 : b0;
        e_ks = win ? k1 : k0;
        last_hs = n;
        prio = !win;
        q.push_back(win);
      end
    end
    tick();
    v0 = 1'b0; v1 = 1'b0; cr = 1'b0;
    chk("rnd final put", put, e_put);
    chk("rnd final rsp0", s0, e_s0);
    chk("rnd final rsp1", s1, e_s1);
    chk("rnd final outstanding", out, q.size());
    tick();
    cr = 1'b1;
    tick();
    cr = 1'b0;
    chk("spurious err", err, 1);
    chk("spurious rsp0", s0, 0);
    chk("spurious rsp1", s1, 0);
    repeat (3) tick();
    chk("err sticky", err, 1);
    v0 = 1'b1; b0 = B1;
    repeat (3) tick();
    v0 = 1'b0;
    chk("pre-reset outstanding", out, 3);
    #2 rst = 1'b1;
    v0 = 1'b1;
    #1;
    chk("async rst put", put, 0);
    chk("async rst block", blk, 0);
    chk("async rst outstanding", out, 0);
    chk("async rst err", err, 0);
    chk("async rst rsp_block", rblk, 0);
    chk("async rst ready0", r0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("restart start_key", start_key, 1);
    tick();
    chk("restart start_key drop", start_key, 0);
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
